// File: rtl/lcd_bus_driver_if.sv
// lcd_bus_driver_if: byte-push handshake from the display formatter plus the
// HD44780 pin bundle (RS/RW/E/DB) driven by lcd_bus_driver.
interface lcd_bus_driver_if;
  logic [7:0] data;
  logic       ins_data;
  logic       send_data;
  logic       ready;
  logic       idle;
  logic       drop;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;

  // Formatter side: pushes bytes and observes flow control and pins
  modport master (
    output data, ins_data, send_data,
    input  ready, idle, drop, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

  // Driver side
  modport slave (
    input  data, ins_data, send_data,
    output ready, idle, drop, lcd_rs, lcd_rw, lcd_e, lcd_db
  );
endinterface

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: queues instruction/data bytes and strobes them onto an
// HD44780-compatible bus in 8-bit or 4-bit mode, waiting out the execution
// time of each byte before taking the next one.
// Optional feature macro: LCD_LONG_CMD_EN (clear/home instructions use
// LONG_EXEC_CYC instead of EXEC_CYC).
module lcd_bus_driver #(
  parameter int unsigned BUS_4BIT      = 0,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_HIGH_CYC    = 12,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 80000
) (
  input  logic               clk,
  input  logic               rst,
  lcd_bus_driver_if.slave    bus
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int unsigned MAX_B   = (EXEC_CYC > LONG_EXEC_CYC) ? EXEC_CYC : LONG_EXEC_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EHI   = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HI,
    ST_GAP,
    ST_EXEC
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_second;
  logic             r_long;
  logic [3:0]       r_lo;
  logic             r_rs;
  logic             r_e;
  logic [7:0]       r_db;

  logic [8:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_ready;
  logic             r_idle;
  logic             r_drop;

  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ_nxt;
  logic             w_idle_nxt;
  logic [8:0]       w_head;
  logic [7:0]       w_db_first;
  logic             w_long;

  assign w_push = bus.send_data & r_ready;
  assign w_pop  = (r_state == ST_IDLE) & (r_occ != '0);
  assign w_head = r_mem[r_rd_ptr];

  // First bus word of a byte: whole byte, or high nibble on lcd_db[7:4]
  assign w_db_first = (BUS_4BIT != 0) ? {w_head[7:4], 4'h0} : w_head[7:0];

`ifdef LCD_LONG_CMD_EN
  // Clear display (01) and return home (02) need the long execution wait
  assign w_long = ~w_head[8] & ((w_head[7:0] == 8'h01) | (w_head[7:0] == 8'h02));
`else
  assign w_long = 1'b0;
`endif

  // Occupancy after this edge, and whether the block is idle after it
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + OCC_W'(1);
    end else if (!w_push && w_pop) begin
      w_occ_nxt = r_occ - OCC_W'(1);
    end
    w_idle_nxt = (w_occ_nxt == '0) &&
                 (((r_state == ST_IDLE) && !w_pop) ||
                  ((r_state == ST_EXEC) && (r_cnt == '0)));
  end

  // FIFO storage; entries are {ins_data, data}
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {bus.ins_data, bus.data};
    end
  end

  // FIFO pointers, occupancy and the registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_ready  <= 1'b1;
      r_idle   <= 1'b1;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ   <= w_occ_nxt;
      r_ready <= (w_occ_nxt != OCC_FULL);
      r_idle  <= w_idle_nxt;
      r_drop  <= bus.send_data & ~r_ready;
    end
  end

  // Bus sequencer: setup, strobe, optional nibble gap, execution wait
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_second <= 1'b0;
      r_long   <= 1'b0;
      r_lo     <= '0;
      r_rs     <= 1'b0;
      r_e      <= 1'b0;
      r_db     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_rs     <= w_head[8];
            r_db     <= w_db_first;
            r_lo     <= w_head[3:0];
            r_long   <= w_long;
            r_second <= 1'b0;
            r_cnt    <= LD_SETUP;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_e     <= 1'b1;
            r_cnt   <= LD_EHI;
            r_state <= ST_E_HI;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_E_HI: begin
          if (r_cnt == '0) begin
            r_e <= 1'b0;
            if ((BUS_4BIT != 0) && !r_second) begin
              r_cnt   <= LD_EHI;
              r_state <= ST_GAP;
            end else begin
              r_cnt   <= r_long ? LD_LONG : LD_EXEC;
              r_state <= ST_EXEC;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_db     <= {r_lo, 4'h0};
            r_second <= 1'b1;
            r_cnt    <= LD_SETUP;
            r_state  <= ST_SETUP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_e     <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.idle   = r_idle;
  assign bus.drop   = r_drop;
  assign bus.lcd_rs = r_rs;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_e  = r_e;
  assign bus.lcd_db = r_db;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: runs an 8-bit and a 4-bit instance on the same byte
// stream and compares every cycle against a timeline model that schedules
// each accepted byte from the pop/strobe/exec timing rules.
module tb_lcd_bus_driver;

  localparam int S  = 2;
  localparam int H  = 4;
  localparam int X  = 20;
  localparam int L  = 100;
  localparam int D  = 4;
`ifdef LCD_LONG_CMD_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  lcd_bus_driver_if bus8 ();
  lcd_bus_driver_if bus4 ();

  lcd_bus_driver #(
    .BUS_4BIT(0), .FIFO_DEPTH(D), .SETUP_CYC(S), .E_HIGH_CYC(H),
    .EXEC_CYC(X), .LONG_EXEC_CYC(L)
  ) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave)
  );

  lcd_bus_driver #(
    .BUS_4BIT(1), .FIFO_DEPTH(D), .SETUP_CYC(S), .E_HIGH_CYC(H),
    .EXEC_CYC(X), .LONG_EXEC_CYC(L)
  ) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );

  always #5 clk = ~clk;

  // One scheduled byte: edge numbers of its pop, strobes, nibble switch, end
  typedef struct {
    int         m;
    int         pop;
    int         r1;
    int         f1;
    int         lo;
    int         r2;
    int         f2;
    int         fin;
    logic [7:0] d;
    logic       rs;
  } ent_t;

  ent_t sched[$];
  int   last_end [2];
  logic mrdy [2];
  logic mdrop [2];
  int   tcur;

  int unsigned n_checks;
  int unsigned n_errors;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h ({ready,idle,drop,rs,rw,e,db})",
               tag, tcur, got, exp);
    end
  endtask

  function automatic int occ_after(input int m);
    int n = 0;
    foreach (sched[i]) if (sched[i].m == m && sched[i].pop > tcur) n++;
    return n;
  endfunction

  // Advance the model by one clock edge with the inputs seen at that edge
  task automatic model_edge(input logic sd, input logic [7:0] d, input logic ins, input logic r);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        last_end[m] = -1000000;
        mrdy[m]     = 1'b1;
        mdrop[m]    = 1'b0;
      end else begin
        mdrop[m] = sd && !mrdy[m];
        if (sd && mrdy[m]) begin
          ent_t e;
          int   xc;
          xc    = (LONG_EN && !ins && (d == 8'h01 || d == 8'h02)) ? L : X;
          e.m   = m;
          e.d   = d;
          e.rs  = ins;
          e.pop = ((tcur > last_end[m]) ? tcur : last_end[m]) + 1;
          e.r1  = e.pop + S;
          e.f1  = e.r1 + H;
          if (m == 1) begin
            e.lo  = e.f1 + H;
            e.r2  = e.lo + S;
            e.f2  = e.r2 + H;
            e.fin = e.f2 + xc;
          end else begin
            e.lo  = e.f1 + xc;
            e.r2  = e.lo;
            e.f2  = e.lo;
            e.fin = e.f1 + xc;
          end
          last_end[m] = e.fin;
          sched.push_back(e);
        end
        mrdy[m] = occ_after(m) < D;
      end
    end
    if (r) sched.delete();
  endtask

  function automatic logic [13:0] exp_vec(input int m);
    logic       e_v  = 1'b0;
    logic       rs_v = 1'b0;
    logic [7:0] db_v = 8'h00;
    logic       idle_v;
    foreach (sched[i]) begin
      if (sched[i].m == m && sched[i].pop <= tcur) begin
        rs_v = sched[i].rs;
        e_v  = (tcur >= sched[i].r1 && tcur < sched[i].f1) ||
               (m == 1 && tcur >= sched[i].r2 && tcur < sched[i].f2);
        if (m == 0)                 db_v = sched[i].d;
        else if (tcur < sched[i].lo) db_v = {sched[i].d[7:4], 4'h0};
        else                         db_v = {sched[i].d[3:0], 4'h0};
      end
    end
    idle_v = (occ_after(m) == 0) && (tcur >= last_end[m]);
    return {mrdy[m], idle_v, mdrop[m], rs_v, 1'b0, e_v, db_v};
  endfunction

  function automatic logic [13:0] got8();
    return {bus8.ready, bus8.idle, bus8.drop, bus8.lcd_rs, bus8.lcd_rw, bus8.lcd_e, bus8.lcd_db};
  endfunction

  function automatic logic [13:0] got4();
    return {bus4.ready, bus4.idle, bus4.drop, bus4.lcd_rs, bus4.lcd_rw, bus4.lcd_e, bus4.lcd_db};
  endfunction

  // Drive one cycle of inputs, clock it, advance the model and compare both
  task automatic step(input logic sd, input logic [7:0] d, input logic ins, input logic r);
    @(negedge clk);
    rst            = r;
    bus8.send_data = sd;
    bus8.data      = d;
    bus8.ins_data  = ins;
    bus4.send_data = sd;
    bus4.data      = d;
    bus4.ins_data  = ins;
    @(posedge clk);
    tcur++;
    model_edge(sd, d, ins, r);
    #1;
    check("bus8", got8(), exp_vec(0));
    check("bus4", got4(), exp_vec(1));
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b1;
    bus8.send_data = 1'b0;
    bus8.data      = 8'h00;
    bus8.ins_data  = 1'b0;
    bus4.send_data = 1'b0;
    bus4.data      = 8'h00;
    bus4.ins_data  = 1'b0;
    n_checks       = 0;
    n_errors       = 0;
    tcur           = 0;
    last_end[0]    = -1000000;
    last_end[1]    = -1000000;
    mrdy[0]        = 1'b1;
    mrdy[1]        = 1'b1;
    mdrop[0]       = 1'b0;
    mdrop[1]       = 1'b0;

    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_state8", got8(), 14'h3000);
    check("rst_state4", got4(), 14'h3000);

    // Single instruction, then single data byte
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    wait_n(45);
    step(1'b1, 8'h2E, 1'b1, 1'b0);
    wait_n(45);

    // Six-cycle burst: five accepted, one dropped
    for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
    wait_n(260);

    // Clear as instruction and as data, home as instruction
    step(1'b1, 8'h01, 1'b0, 1'b0);
    wait_n(140);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    wait_n(60);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    wait_n(140);

    // Reset in the middle of a strobe with two entries queued
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    wait_n(3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_mid8", got8(), 14'h3000);
    check("rst_mid4", got4(), 14'h3000);
    wait_n(60);

    // Nine spaced bytes walk the pointers around the ring
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'h41 + 8'(i), 1'b1, 1'b0);
      wait_n(39);
    end

    // Random traffic with occasional bursts, clear/home and resets
    for (int i = 0; i < 2500; i++) begin
      logic       sd;
      logic [7:0] d;
      logic       ins;
      logic       r;
      sd  = ($urandom_range(0, 5) == 0) || ($urandom_range(0, 99) < 3);
      ins = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      r   = ($urandom_range(0, 399) == 0);
      step(sd, d, ins, r);
    end
    wait_n(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Parametrised successor to `lcd_disp_interface`: accepts instruction/data bytes from the clock-display logic through a small queue and drives an HD44780-compatible LCD bus (RS/RW/E/DB). It adds 4-bit or 8-bit bus mode, a FIFO so callers can burst bytes without waiting, per-byte execution wait, and a ready/drop handshake. It sits between the display formatter (`lcd_top`) and the LCD pins.

## Interface
- `BUS_4BIT`, 0: 0 = 8-bit bus on `lcd_db[7:0]`; 1 = 4-bit bus on `lcd_db[7:4]`, `lcd_db[3:0]` driven 0.
- `FIFO_DEPTH`, 4: queue entries; power of two, at least 2.
- `SETUP_CYC`, 2: cycles RS/DB are stable before E rises; at least 1.
- `E_HIGH_CYC`, 12: E high width in cycles, also the 4-bit nibble gap; at least 1.
- `EXEC_CYC`, 2000: wait after the last E fall of a normal byte.
- `LONG_EXEC_CYC`, 80000: wait after a clear/home instruction (only with `LCD_LONG_CMD_EN`).
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `data`  input  8  byte to send.
- `ins_data`  input  1  0 = instruction (RS=0), 1 = character data (RS=1).
- `send_data`  input  1  push request, sampled every rising edge.
- `ready`  output  1  FIFO not full.
- `idle`  output  1  FIFO empty and FSM in IDLE.
- `drop`  output  1  one-cycle pulse when a push is rejected.
- `lcd_rs`  output  1  LCD register select.
- `lcd_rw`  output  1  constant 0 (write only).
- `lcd_e`  output  1  LCD enable strobe.
- `lcd_db`  output  8  LCD data bus.

## Operation
- Push: on a rising edge with `send_data`=1 and `ready`=1, `{ins_data,data}` is written to the FIFO. Each high cycle pushes one entry, so holding `send_data` high for N cycles pushes N entries.
- A push attempted while full is discarded, the FIFO is unchanged, and `drop` pulses for one cycle. A pop on the same edge does not rescue it: `ready` is evaluated before the edge.
- FSM states: IDLE, SETUP, E_HI, GAP, EXEC.
  - IDLE -> SETUP when the FIFO is non-empty. The head is popped on that edge, and `lcd_rs`/`lcd_db` are loaded in 8-bit mode, or the high nibble in 4-bit mode.
  - SETUP runs for SETUP_CYC cycles, then E_HI with `lcd_e`=1 for E_HIGH_CYC cycles.
  - 8-bit mode: E_HI -> EXEC.
  - 4-bit mode, first nibble: E_HI -> GAP. GAP lasts E_HIGH_CYC cycles with `lcd_e`=0 and the bus held. On exit, the low nibble is loaded onto `lcd_db[7:4]` and the FSM goes to SETUP again.
  - 4-bit mode, second nibble: E_HI -> EXEC.
  - EXEC waits the selected execution count with `lcd_e`=0 and the bus held, then returns to IDLE.
- There is one cycle-count down-counter, sized to `$clog2` of the largest parameter plus 1. FIFO pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap; an occupancy count of `$clog2(FIFO_DEPTH)+1` bits separates full from empty.
- Reset mid-operation flushes the FIFO, forces IDLE, and drives `lcd_e` low on the same edge. A strobe may be cut short.

## Timing
- Reset values: `ready`=1, `idle`=1, `drop`=0, `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_db`=0.
- All outputs are registered.
- With a push at edge p into an empty, idle block, the pop happens at edge p+1.
- 8-bit mode:
  - `lcd_e` rises at p+1+S and falls at p+1+S+H (S = SETUP_CYC, H = E_HIGH_CYC).
  - `idle` returns at p+1+S+H+X (X = exec count).
- 4-bit mode:
  - The first strobe is as in 8-bit mode.
  - The low nibble appears at fall1+H.
  - The second strobe rises at fall1+H+S and falls H later.
  - The EXEC wait follows the second fall.
- Back-to-back bytes: the next pop occurs one cycle after EXEC ends.
- `ready` drops on the edge the FIFO becomes full and rises on the edge of the pop.

## Configuration
- `LCD_LONG_CMD_EN` defined: an instruction (`ins_data`=0) with `data` equal to 8'h01 or 8'h02 (clear/home) uses LONG_EXEC_CYC. All other bytes use EXEC_CYC.
- `LCD_LONG_CMD_EN` undefined: every byte uses EXEC_CYC, and the LONG_EXEC_CYC parameter is ignored.

## Test plan
All scenarios use S=2, H=4, EXEC_CYC=20, LONG_EXEC_CYC=100, FIFO_DEPTH=4.

- 8-bit mode, push instruction 8'h0A at edge 0 -> `lcd_db`=8'h0A and `lcd_rs`=0 at edge 1; `lcd_e` high at edges 3..6 and low at 7; `idle`=1 at edge 27.
- 4-bit mode, push data 8'h2E (`ins_data`=1) -> `lcd_rs`=1, `lcd_db`=8'h20 during strobe 1 (edges 3..6); `lcd_db`=8'hE0 from edge 11; strobe 2 at edges 13..16; `idle`=1 at edge 37.
- Hold `send_data` high for 6 cycles with a busy FSM -> 5 entries are accepted (1 popped plus 4 queued), `ready`=0, and `drop` pulses once. All 5 bytes then appear on the bus in order.
- Instruction 8'h01 -> E falls, then 100 cycles to `idle` with the macro defined, or 20 cycles without it. Data 8'h01 always takes 20 cycles.
- Assert `rst` at edge 4 of a strobe with 2 entries queued -> `lcd_e`=0, `lcd_db`=0, `ready`=1, `idle`=1 after that edge, and no further strobes.
- Push 9 bytes spaced 40 cycles apart -> pointer wrap is exercised and the bytes appear on the bus in order with no drops.
